// File: rtl/uart_tst_gen.sv
// uart_tst_gen: UART exerciser; echo (mode 0) or incrementing-pattern loopback self-test (mode 1).
// Optional receive/transmit watchdog is built when UART_TST_WDOG_EN is defined.
module uart_tst_gen #(
    parameter int                DATA_W   = 8,
    parameter int                ECHO_INC = 1,
    parameter logic [DATA_W-1:0] SEED     = 8'h54,
    parameter int                CNT_W    = 16,
    parameter int                TO_CYC   = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              mode,
    input  logic              rx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [DATA_W-1:0] tx_data,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [DATA_W-1:0] last_bad,
    output logic              timeout,
    output logic              busy
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        E_WAIT    = 4'd1,
        E_PREP    = 4'd2,
        E_START   = 4'd3,
        E_HOLD    = 4'd4,
        E_WAIT_TX = 4'd5,
        L_SEND    = 4'd6,
        L_WAIT    = 4'd7,
        L_CHECK   = 4'd8
    } state_t;

    localparam logic [DATA_W-1:0] ECHO_ADD = DATA_W'(ECHO_INC);

    state_t            state;
    logic [DATA_W-1:0] rx_hold;
    logic              rx_flag;
    logic [DATA_W-1:0] pattern;
    logic [DATA_W-1:0] exp_word;

    logic       wd_fire;
    logic       consume;
    logic       overrun;
    logic       mismatch;
    logic [1:0] err_inc;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] val, input logic [1:0] inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, val} + {{(CNT_W-1){1'b0}}, inc};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

    // A word arriving in a consume cycle replaces the one being consumed and is not an overrun.
    assign consume  = (state == E_PREP) || (state == L_CHECK) || wd_fire;
    assign overrun  = rx_ready && rx_flag && !consume;
    assign mismatch = (state == L_CHECK) && (rx_hold != exp_word);
    assign err_inc  = {1'b0, overrun} + {1'b0, mismatch} + {1'b0, wd_fire};
    assign busy     = (state != IDLE);

`ifdef UART_TST_WDOG_EN
    localparam int WD_W = $clog2(TO_CYC + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            wd_run;

    assign wd_run  = (state == E_WAIT_TX) || (state == L_WAIT);
    assign wd_fire = wd_run && (wd_cnt == WD_W'(TO_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            wd_cnt <= (wd_run && !wd_fire) ? wd_cnt + 1'b1 : '0;
            if (wd_fire) timeout <= 1'b1;
        end
    end
`else
    assign wd_fire = 1'b0;
    assign timeout = 1'b0;
`endif

    // NOTE: every register here uses non-blocking assignment so all branches see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
            pass_cnt <= '0;
            err_cnt  <= '0;
            last_bad <= '0;
            rx_hold  <= '0;
            rx_flag  <= 1'b0;
            pattern  <= SEED;
            exp_word <= '0;
        end else begin
            if (rx_ready) begin
                rx_hold <= rx_data;
                rx_flag <= 1'b1;
            end else if (consume) begin
                rx_flag <= 1'b0;
            end

            if (err_inc != 2'd0) err_cnt <= sat_add(err_cnt, err_inc);

            if (wd_fire) begin
                tx_start <= 1'b0;
                state    <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (enable) state <= mode ? L_SEND : E_WAIT;
                    end
                    E_WAIT: begin
                        if (!enable)     state <= IDLE;
                        else if (rx_flag) state <= E_PREP;
                    end
                    E_PREP: begin
                        tx_data <= rx_hold + ECHO_ADD;
                        state   <= E_START;
                    end
                    E_START: begin
                        if (!tx_busy) begin
                            tx_start <= 1'b1;
                            state    <= E_HOLD;
                        end
                    end
                    E_HOLD: begin
                        tx_start <= 1'b0;
                        state    <= E_WAIT_TX;
                    end
                    E_WAIT_TX: begin
                        if (!tx_busy) state <= enable ? E_WAIT : IDLE;
                    end
                    L_SEND: begin
                        if (!tx_busy) begin
                            tx_data  <= pattern;
                            exp_word <= pattern;
                            pattern  <= pattern + 1'b1;
                            tx_start <= 1'b1;
                            state    <= L_WAIT;
                        end
                    end
                    L_WAIT: begin
                        tx_start <= 1'b0;
                        if (rx_flag && !tx_busy) state <= L_CHECK;
                    end
                    L_CHECK: begin
                        if (mismatch) last_bad <= rx_hold;
                        else          pass_cnt <= sat_add(pass_cnt, 2'd1);
                        state <= enable ? L_SEND : IDLE;
                    end
                    default: begin
                        tx_start <= 1'b0;
                        state    <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tst_gen.sv
// tb_uart_tst_gen: randomized check of uart_tst_gen echo and loopback against a transaction-level model.
`timescale 1ns/1ps
module tb_uart_tst_gen;

    localparam int         DATA_W  = 8;
    localparam int         CNT_W   = 5;
    localparam logic [7:0] SEED    = 8'h54;
    localparam int         CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic              mode;
    logic              rx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              tx_busy;
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic [CNT_W-1:0]  pass_cnt;
    logic [CNT_W-1:0]  err_cnt;
    logic [DATA_W-1:0] last_bad;
    logic              timeout;
    logic              busy;

    uart_tst_gen #(
        .DATA_W(DATA_W), .ECHO_INC(1), .SEED(SEED), .CNT_W(CNT_W), .TO_CYC(100000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode),
        .rx_ready(rx_ready), .rx_data(rx_data), .tx_busy(tx_busy),
        .tx_start(tx_start), .tx_data(tx_data), .pass_cnt(pass_cnt), .err_cnt(err_cnt),
        .last_bad(last_bad), .timeout(timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } start_t;

    start_t     got_q[$];
    int         cyc        = 0;
    int         viol       = 0;
    logic       prev_start = 1'b0;
    int         n_checks   = 0;
    int         n_pass     = 0;

    // Reference model state: counters, last bad word and the next loopback pattern.
    int         pass_exp     = 0;
    int         err_exp      = 0;
    logic [7:0] last_bad_exp = 8'h00;
    logic [7:0] exp_pat      = SEED;

    // Start-pulse monitor, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (tx_start) begin
            got_q.push_back('{cyc, tx_data});
            if (prev_start || tx_busy) viol++;
        end
        prev_start = tx_start;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic pulse_rx(input logic [7:0] w);
        rx_data  = w;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic wait_start(input string tag, input int budget, output bit ok, output int at,
                              output logic [7:0] d);
        start_t s;
        ok = 1'b0;
        at = 0;
        d  = 8'h00;
        for (int i = 0; i < budget && got_q.size() == 0; i++) @(negedge clk);
        if (got_q.size() != 0) begin
            s  = got_q.pop_front();
            ok = 1'b1;
            at = s.cyc;
            d  = s.data;
        end
        check({tag, "_start_seen"}, 32'(ok), 32'd1);
    endtask

    task automatic echo_one(input logic [7:0] w);
        int         c, at;
        bit         ok;
        logic [7:0] d, e;
        c = cyc;
        e = w + 8'd1;
        pulse_rx(w);
        wait_start("echo", 20, ok, at, d);
        if (ok) begin
            check("echo_data", d, e);
            check("echo_latency", at, c + 4);
        end
    endtask

    // Echo w0, then hold tx_busy while one (or two, overrunning) further words arrive.
    task automatic busy_echo(input logic [7:0] w0, input logic [7:0] a, input logic [7:0] b,
                             input bit two, input int hold);
        int         d, at;
        bit         ok;
        logic [7:0] got, e;
        echo_one(w0);
        @(negedge clk);
        tx_busy = 1'b1;
        repeat (3) @(negedge clk);
        pulse_rx(a);
        if (two) begin
            @(negedge clk);
            pulse_rx(b);
            if (err_exp < CNT_MAX) err_exp++;
        end
        repeat (hold) @(negedge clk);
        check("busy_no_start", got_q.size(), 0);
        d       = cyc;
        tx_busy = 1'b0;
        e       = (two ? b : a) + 8'd1;
        wait_start("busy_rel", 20, ok, at, got);
        if (ok) begin
            check("busy_rel_data", got, e);
            check("busy_rel_latency", at, d + 4);
        end
        check("busy_err_cnt", err_cnt, err_exp);
    endtask

    // One loopback word through a behavioural UART: busy for a while, then return (maybe corrupted).
    task automatic loop_word(input bit corrupt, input logic [7:0] bad, input bit last);
        int         at;
        bit         ok;
        logic [7:0] d, reply;
        wait_start("lb", 40, ok, at, d);
        if (!ok) return;
        check("lb_word", d, exp_pat);
        reply = corrupt ? bad : exp_pat;
        if (reply == exp_pat) begin
            if (pass_exp < CNT_MAX) pass_exp++;
        end else begin
            if (err_exp < CNT_MAX) err_exp++;
            last_bad_exp = reply;
        end
        exp_pat = exp_pat + 8'd1;
        mode    = 1'($urandom);
        if (last) enable = 1'b0;
        @(negedge clk);
        tx_busy = 1'b1;
        repeat ($urandom_range(2, 8)) @(negedge clk);
        tx_busy = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        pulse_rx(reply);
        repeat (2) @(negedge clk);
        check("lb_pass_cnt", pass_cnt, pass_exp);
        check("lb_err_cnt", err_cnt, err_exp);
        check("lb_last_bad", last_bad, last_bad_exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, got t=%0t expected completion", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b0;
        mode     = 1'b0;
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        tx_busy  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_pass_cnt", pass_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_last_bad", last_bad, 0);
        check("rst_timeout", timeout, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;

        // Echo mode: fixed word, random words, wrap with long busy, then overrun.
        enable = 1'b1;
        mode   = 1'b0;
        repeat (2) @(negedge clk);
        echo_one(8'h41);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            echo_one(8'($urandom_range(0, 255)));
            repeat (4) @(negedge clk);
        end
        busy_echo(8'hFF, 8'h30, 8'h00, 1'b0, 15);
        repeat (4) @(negedge clk);
        busy_echo(8'h11, 8'($urandom), 8'($urandom), 1'b1, 4);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        check("echo_disable_idle", busy, 0);

        // Reset while the start pulse is high.
        enable = 1'b1;
        repeat (2) @(negedge clk);
        echo_one(8'h77);
        rst_n = 1'b0;
        #1;
        check("rst_mid_tx_start", tx_start, 0);
        check("rst_mid_tx_data", tx_data, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_err_cnt", err_cnt, 0);
        enable       = 1'b0;
        pass_exp     = 0;
        err_exp      = 0;
        last_bad_exp = 8'h00;
        exp_pat      = SEED;
        got_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Loopback: clean run, single corruption, random corruption, saturation, re-entry.
        mode   = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 10; i++) loop_word(1'b0, 8'h00, 1'b0);
        check("lb_ten_pass", pass_cnt, 10);
        check("lb_ten_err", err_cnt, 0);
        for (int i = 0; i < 10; i++) loop_word(i == 2, 8'h00, 1'b0);
        check("lb_corrupt_err", err_cnt, 1);
        check("lb_corrupt_last_bad", last_bad, 8'h00);
        for (int i = 0; i < 12; i++) loop_word($urandom_range(0, 2) == 0, 8'($urandom), 1'b0);
        for (int i = 0; i < 40; i++) loop_word(1'b1, ~exp_pat, i == 39);
        check("lb_err_saturated", err_cnt, CNT_MAX);
        repeat (4) @(negedge clk);
        check("lb_stop_idle", busy, 0);
        mode   = 1'b1;
        enable = 1'b1;
        loop_word(1'b0, 8'h00, 1'b0);
        loop_word(1'b0, 8'h00, 1'b1);
        repeat (4) @(negedge clk);
        check("lb_reentry_idle", busy, 0);

        check("start_pulse_rules", viol, 0);
        check("timeout_flag", timeout, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
